// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default constants for the data-RAM arbiter.
// The fetch and memory stages import this package so that they agree with the
// arbiter on state/owner encodings and on the default latency and starve bound.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnMem  = 2'd2
  } arb_owner_e;

  localparam int unsigned DEFAULT_LATENCY    = 2;
  localparam int unsigned DEFAULT_STARVE_MAX = 4;

  // Wide enough for LATENCY-1 (max 3) and STARVE_MAX (max 15).
  localparam int unsigned LAT_CNT_W    = 2;
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while fetch is waiting.
// Ports:
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   if_req_i         - fetch request currently pending
//   data_grant_i     - data requester granted this cycle
//   fetch_grant_i    - fetch requester granted this cycle
//   force_fetch_o    - bound reached: the next arbitration must favour fetch
module arb_starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic data_grant_i,
  input  logic fetch_grant_i,
  output logic force_fetch_o
);

  localparam logic [STARVE_CNT_W-1:0] CntMax = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!if_req_i || fetch_grant_i) begin
      // Nobody is starving, or fetch just got served.
      cnt_q <= '0;
    end else if (data_grant_i && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    force_fetch_o = (cnt_q == CntMax);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port data RAM between fetch (reads only) and the
// memory stage (loads/stores). One transaction in flight at a time.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   if_req/if_addr/if_flush       - fetch request, address, redirect discard
//   if_gnt/if_rvalid/if_rdata     - fetch grant pulse, data valid pulse, data
//   mem_req/mem_we/mem_addr/mem_wdata - data request
//   mem_gnt/mem_rvalid/mem_rdata  - data grant pulse, completion pulse, load data
//   ram_address/ram_data_in/ram_write_enable/ram_data_out - RAM interface
//   busy                          - a transaction is in progress
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = DEFAULT_LATENCY,
  parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LatLoad = LAT_CNT_W'(LATENCY - 1);

  arb_state_e           state_q;
  arb_owner_e           owner_q;
  logic [LAT_CNT_W-1:0] lat_cnt_q;
  logic                 flush_pend_q;
  logic                 if_rvalid_q;
  logic                 mem_rvalid_q;
  logic [DATA_W-1:0]    if_rdata_q;
  logic [DATA_W-1:0]    mem_rdata_q;
  logic [ADDR_W-1:0]    ram_address_q;
  logic [DATA_W-1:0]    ram_data_in_q;
  logic                 ram_we_q;

  logic force_fetch;
  logic arb_idle;
  logic if_win;
  logic mem_win;

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i        (clk),
    .rst_ni       (rst),
    .if_req_i     (if_req),
    .data_grant_i (mem_win),
    .fetch_grant_i(if_win),
    .force_fetch_o(force_fetch)
  );

  // Arbitration only in IDLE; rst gating keeps grants low while in reset.
  always_comb begin
    arb_idle = (state_q == StIdle) && rst;
    if_win   = arb_idle && if_req && (!mem_req || force_fetch);
    mem_win  = arb_idle && mem_req && !if_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      owner_q       <= OwnNone;
      lat_cnt_q     <= '0;
      flush_pend_q  <= 1'b0;
      if_rvalid_q   <= 1'b0;
      mem_rvalid_q  <= 1'b0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_win) begin
            state_q       <= StRead;
            owner_q       <= OwnIf;
            ram_address_q <= if_addr;
            lat_cnt_q     <= LatLoad;
            flush_pend_q  <= if_flush;
          end else if (mem_win) begin
            owner_q       <= OwnMem;
            ram_address_q <= mem_addr;
            ram_data_in_q <= mem_wdata;
            flush_pend_q  <= 1'b0;
            if (mem_we) begin
              state_q  <= StWrite;
              ram_we_q <= 1'b1;
            end else begin
              state_q   <= StRead;
              lat_cnt_q <= LatLoad;
            end
          end
        end
        StWrite: begin
          ram_we_q     <= 1'b0;
          mem_rvalid_q <= 1'b1;
          owner_q      <= OwnNone;
          state_q      <= StIdle;
        end
        StRead: begin
          if ((owner_q == OwnIf) && if_flush) begin
            flush_pend_q <= 1'b1;
          end
          if (lat_cnt_q == '0) begin
            state_q      <= StIdle;
            owner_q      <= OwnNone;
            flush_pend_q <= 1'b0;
            if (owner_q == OwnMem) begin
              mem_rdata_q  <= ram_data_out;
              mem_rvalid_q <= 1'b1;
            end else if ((owner_q == OwnIf) && !flush_pend_q && !if_flush) begin
              // A redirect seen anywhere since the grant drops the result.
              if_rdata_q  <= ram_data_out;
              if_rvalid_q <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          owner_q  <= OwnNone;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    if_gnt           = if_win;
    mem_gnt          = mem_win;
    // A redirect coinciding with the valid pulse still kills it.
    if_rvalid        = if_rvalid_q && !if_flush;
    if_rdata         = if_rdata_q;
    mem_rvalid       = mem_rvalid_q;
    mem_rdata        = mem_rdata_q;
    ram_address      = ram_address_q;
    ram_data_in      = ram_data_in_q;
    ram_write_enable = ram_we_q;
    busy             = (state_q != StIdle);
  end

endmodule
